muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide execute unit. It sits directly downstream of the register file and consumes the regdataR1/regdataR2 read operands.
- Its result feeds the register file write port directly: wdata, regaddrW and regwrite.
- It uses iterative shift-add multiplication and restoring division, with one bit per cycle and fixed latency. This keeps area small in exchange for throughput.

Parameters:
- n, 32, operand/result width in bits. Iteration count equals n.

Ports:
- clock  input  1  system clock; all state updates on posedge clock
- nreset  input  1  synchronous active-low reset, sampled on posedge clock
- start  input  1  request; accepted only when busy=0
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opA  input  n  rs1 operand (from regdataR1)
- opB  input  n  rs2 operand (from regdataR2)
- rdaddr  input  6  destination register address, passed through to regaddrW
- busy  output  1  high while an operation is in flight
- regwrite  output  1  one-cycle write strobe to the register file
- regaddrW  output  6  captured destination address
- wdata  output  n  result value

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-low.
- Reset (nreset=0 at a posedge): state=IDLE; busy=0, regwrite=0, regaddrW=0, wdata=0; counter and datapath registers cleared.
- Reset mid-operation: the operation is aborted, no regwrite is issued, and the unit is back in IDLE on the next cycle.
- States: IDLE, MUL, DIV, DONE.
- IDLE: if start=1, capture funct3, rdaddr, and sign-corrected operand magnitudes. Go to MUL when funct3[2]=0, DIV when funct3[2]=1. Load counter with n.
- Signedness by op:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats opA as signed and opB as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
- Sign handling: take absolute values of signed operands, run the unsigned datapath, then negate at the end.
  - Product sign = sign(A) xor sign(B).
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
- MUL state: per cycle, if multiplier LSB=1, add the multiplicand to the upper half of a 2n-bit accumulator; then shift right by 1. Decrement the counter; at 0, go to DONE.
- DIV state: restoring division, one quotient bit per cycle, MSB first. Decrement the counter; at 0, go to DONE.
- DONE: drive wdata and regwrite=1 for exactly one cycle, then go to IDLE.
  - MUL returns the low n bits of the signed product.
  - MULH, MULHSU and MULHU return the high n bits.
  - DIV and DIVU return the quotient.
  - REM and REMU return the remainder.
- Latency: start sampled at edge T → busy=1 from T+1 through T+n+1 → regwrite=1 during cycle T+n+1 only. This is 33 cycles for n=32, identical for every op.
- Back-to-back: busy falls after DONE, so a new start is accepted in the cycle after regwrite. Minimum issue interval is n+2 cycles.
- start while busy=1: ignored; captured operands are unaffected.
- Divide by zero (no trap, fixed latency kept):
  - DIV/DIVU return all ones.
  - REM/REMU return opA unchanged.
- Signed overflow (opA = -2^(n-1), opB = -1): DIV returns -2^(n-1); REM returns 0.
- Writes to register 0: rdaddr=0 still runs the full latency, but regwrite stays 0 in DONE.
- Holding values: wdata and regaddrW hold their last values after DONE until the next DONE; they are only meaningful when regwrite=1.

Test Plan:
- Reset then idle: hold nreset=0 for 2 cycles, release, no start → busy=0, regwrite=0, wdata=0 on every cycle.
- MUL and MULH: opA=0xFFFFFFFF (-1), opB=0x00000007.
  - MUL, rd=5 → regwrite pulses once at T+33 with wdata=0xFFFFFFF9, regaddrW=5.
  - MULH → wdata=0xFFFFFFFF.
  - MULHU → wdata=0x00000006.
  - MULHSU → wdata=0xFFFFFFFF.
- DIV/REM signs: opA=-7 (0xFFFFFFF9), opB=2.
  - DIV → 0xFFFFFFFD (-3).
  - REM → 0xFFFFFFFF (-1).
  - DIVU → 0x7FFFFFFC.
  - REMU → 1.
- Corner cases: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0; DIVU 123/0 → 0xFFFFFFFF; REMU 123/0 → 123. Each completes at T+33.
- Handshake:
  - Assert start again at T+5 with different operands → ignored, first result unchanged.
  - Then start in the cycle after regwrite → accepted, next regwrite n+2 cycles after the first.
- Abort and x0: pull nreset low at T+10 → no regwrite ever and busy=0 after reset. Then issue MUL with rd=0 → busy runs 33 cycles and regwrite stays 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on
// accept, one bit is processed per cycle (shift-add multiply or restoring
// divide), and the sign is reapplied to the final result.
module muldiv_unit #(
    parameter int n = 32
) (
    input  logic         clock,
    input  logic         nreset,
    input  logic         start,
    input  logic [2:0]   funct3,
    input  logic [n-1:0] opA,
    input  logic [n-1:0] opB,
    input  logic [5:0]   rdaddr,
    output logic         busy,
    output logic         regwrite,
    output logic [5:0]   regaddrW,
    output logic [n-1:0] wdata
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]   op_q, op_d;
    logic [5:0]   rd_q, rd_d;
    logic [n-1:0] a_q, a_d;          // multiplicand magnitude
    logic [n-1:0] b_q, b_d;          // divisor magnitude
    logic [2*n-1:0] acc_q, acc_d;    // {upper, lower}: product/multiplier or remainder/quotient
    logic         sgn_q, sgn_d;      // sign of product / quotient
    logic         sa_q, sa_d;        // sign of remainder (sign of A)
    logic         bz_q, bz_d;        // divisor was zero
    logic         busy_q, busy_d;
    logic         regwrite_q, regwrite_d;
    logic [5:0]   regaddrw_q, regaddrw_d;
    logic [n-1:0] wdata_q, wdata_d;

    logic         a_signed, b_signed, sa_in, sb_in;
    logic [n-1:0] a_mag, b_mag;
    logic [n:0]   mul_sum;
    logic [2*n-1:0] mul_next, prod_s;
    logic [n:0]   div_shift, div_diff;
    logic         div_ok;
    logic [2*n-1:0] div_next;
    logic [n-1:0] quo_s, rem_s, result;

    // Next-state, iteration datapath and result formatting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rd_d       = rd_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        sgn_d      = sgn_q;
        sa_d       = sa_q;
        bz_d       = bz_q;
        busy_d     = busy_q;
        regwrite_d = 1'b0;
        regaddrw_d = regaddrw_q;
        wdata_d    = wdata_q;

        // Only MULHU/DIVU/REMU treat A as unsigned; B is also unsigned for MULHSU.
        a_signed = ~(funct3[0] & (funct3[1] | funct3[2]));
        b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
        sa_in    = a_signed & opA[n-1];
        sb_in    = b_signed & opB[n-1];
        a_mag    = sa_in ? -opA : opA;
        b_mag    = sb_in ? -opB : opB;

        // One shift-add step: conditional add into the upper half, then shift right.
        mul_sum  = {1'b0, acc_q[2*n-1:n]} + (acc_q[0] ? {1'b0, a_q} : {(n+1){1'b0}});
        mul_next = {mul_sum, acc_q[n-1:1]};
        prod_s   = sgn_q ? -mul_next : mul_next;

        // One restoring step: shift next dividend bit into the remainder, try subtract.
        div_shift = {acc_q[2*n-1:n], acc_q[n-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ok    = ~div_diff[n];
        div_next  = {(div_ok ? div_diff[n-1:0] : div_shift[n-1:0]), acc_q[n-2:0], div_ok};
        // A zero divisor yields an all-ones quotient; it must not be negated.
        quo_s     = (sgn_q & ~bz_q) ? -div_next[n-1:0] : div_next[n-1:0];
        rem_s     = sa_q ? -div_next[2*n-1:n] : div_next[2*n-1:n];

        case (op_q)
            3'b000:                 result = prod_s[n-1:0];
            3'b001, 3'b010, 3'b011: result = prod_s[2*n-1:n];
            3'b100, 3'b101:         result = quo_s;
            default:                result = rem_s;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = funct3;
                    rd_d    = rdaddr;
                    a_d     = a_mag;
                    b_d     = b_mag;
                    sgn_d   = sa_in ^ sb_in;
                    sa_d    = sa_in;
                    bz_d    = (opB == '0);
                    acc_d   = {{n{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                    cnt_d   = CW'(n);
                    busy_d  = 1'b1;
                    state_d = funct3[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_MUL) ? mul_next : div_next;
                cnt_d = cnt_q - CW'(1);
                // The last iteration's result is formatted straight into the output flops.
                if (cnt_q == CW'(1)) begin
                    state_d    = S_DONE;
                    wdata_d    = result;
                    regaddrw_d = rd_q;
                    regwrite_d = (rd_q != 6'd0);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            sgn_q      <= 1'b0;
            sa_q       <= 1'b0;
            bz_q       <= 1'b0;
            busy_q     <= 1'b0;
            regwrite_q <= 1'b0;
            regaddrw_q <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            sgn_q      <= sgn_d;
            sa_q       <= sa_d;
            bz_q       <= bz_d;
            busy_q     <= busy_d;
            regwrite_q <= regwrite_d;
            regaddrw_q <= regaddrw_d;
            wdata_q    <= wdata_d;
        end
    end

    assign busy     = busy_q;
    assign regwrite = regwrite_q;
    assign regaddrW = regaddrw_q;
    assign wdata    = wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, handshake,
// abort and x0-destination behaviour.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        nreset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opA, opB;
    logic [5:0]  rdaddr;
    logic        busy, regwrite;
    logic [5:0]  regaddrW;
    logic [31:0] wdata;

    int vectors = 0;
    int miscompares = 0;
    time rw_time = 0;
    time first_rw = 0;

    muldiv_unit #(.n(32)) dut (
        .clock(clock), .nreset(nreset), .start(start), .funct3(funct3),
        .opA(opA), .opB(opB), .rdaddr(rdaddr), .busy(busy),
        .regwrite(regwrite), .regaddrW(regaddrW), .wdata(wdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op from a sampling point (#1 after a posedge); optionally poke a
    // conflicting start mid-flight. Leaves time at the cycle after regwrite.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] rd,
                          input logic [31:0] exp, input bit inject);
        int lat;
        funct3 = f; opA = a; opB = b; rdaddr = rd; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        while (!regwrite && lat < 40) begin
            if (inject && lat == 5) begin
                funct3 = 3'b100; opA = 32'd99; opB = 32'd3; rdaddr = 6'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            lat++;
        end
        start = 1'b0;
        rw_time = $time;
        chk({tag, " latency"}, lat, 32'd33);
        chk({tag, " wdata"}, wdata, exp);
        chk({tag, " regaddrW"}, {26'd0, regaddrW}, {26'd0, rd});
        @(posedge clock); #1;
        chk({tag, " strobe 1 cycle"}, {31'd0, regwrite}, 32'd0);
        chk({tag, " busy released"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int bc;
        bit saw_rw;
        nreset = 1'b0; start = 1'b0; funct3 = '0; opA = '0; opB = '0; rdaddr = '0;
        repeat (2) @(posedge clock);
        #1 nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("reset busy", {31'd0, busy}, 32'd0);
            chk("reset regwrite", {31'd0, regwrite}, 32'd0);
            chk("reset wdata", wdata, 32'd0);
            @(posedge clock); #1;
        end
        chk("reset regaddrW", {26'd0, regaddrW}, 32'd0);

        run_op("MUL",    3'b000, 32'hFFFFFFFF, 32'd7, 6'd5, 32'hFFFFFFF9, 0);
        run_op("MULH",   3'b001, 32'hFFFFFFFF, 32'd7, 6'd5, 32'hFFFFFFFF, 0);
        run_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'd7, 6'd5, 32'h00000006, 0);
        run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd7, 6'd5, 32'hFFFFFFFF, 0);

        run_op("DIV",  3'b100, 32'hFFFFFFF9, 32'd2, 6'd6, 32'hFFFFFFFD, 0);
        run_op("REM",  3'b110, 32'hFFFFFFF9, 32'd2, 6'd6, 32'hFFFFFFFF, 0);
        run_op("DIVU", 3'b101, 32'hFFFFFFF9, 32'd2, 6'd6, 32'h7FFFFFFC, 0);
        run_op("REMU", 3'b111, 32'hFFFFFFF9, 32'd2, 6'd6, 32'h00000001, 0);

        run_op("DIV ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 6'd8, 32'h80000000, 0);
        run_op("REM ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 6'd8, 32'h00000000, 0);
        run_op("DIVU /0",  3'b101, 32'd123, 32'd0, 6'd8, 32'hFFFFFFFF, 0);
        run_op("REMU /0",  3'b111, 32'd123, 32'd0, 6'd8, 32'd123, 0);
        run_op("DIV -5/0", 3'b100, 32'hFFFFFFFB, 32'd0, 6'd8, 32'hFFFFFFFF, 0);
        run_op("REM -5/0", 3'b110, 32'hFFFFFFFB, 32'd0, 6'd8, 32'hFFFFFFFB, 0);

        // Start while busy is ignored; next start right after regwrite is taken.
        run_op("MUL inject", 3'b000, 32'd3, 32'd4, 6'd7, 32'd12, 1);
        first_rw = rw_time;
        run_op("MULHU b2b", 3'b011, 32'h80000000, 32'd4, 6'd10, 32'd2, 0);
        chk("issue interval", 32'(rw_time - first_rw), 32'd340);

        // Abort: reset sampled at T+10 kills the op.
        funct3 = 3'b000; opA = 32'd5; opB = 32'd6; rdaddr = 6'd11; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1 nreset = 1'b0;
        @(posedge clock); #1;
        nreset = 1'b1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        saw_rw = 1'b0;
        repeat (40) begin
            if (regwrite) saw_rw = 1'b1;
            @(posedge clock); #1;
        end
        chk("abort no regwrite", {31'd0, saw_rw}, 32'd0);

        // Destination x0: full latency, no write strobe.
        funct3 = 3'b000; opA = 32'd5; opB = 32'd6; rdaddr = 6'd0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        bc = 0; saw_rw = 1'b0;
        repeat (40) begin
            if (busy) bc++;
            if (regwrite) saw_rw = 1'b1;
            @(posedge clock); #1;
        end
        chk("x0 busy cycles", bc, 32'd33);
        chk("x0 no regwrite", {31'd0, saw_rw}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
